pio_bank: RTL and testbench

- Parametrised multi-channel parallel I/O bank: generalises the per-colour 8-bit and 18-bit switch PIOs into one Avalon-MM slave with CHANNELS identical in/out lanes.
- Sits on the Nios data bus alongside the SD card interface.
- Adds input synchronisers, per-bit edge capture, an interrupt mask, and atomic set/clear of outputs.

---
 rtl/pio_bank_if.sv | 14 +
 rtl/pio_bank.sv | 159 +++++++++++++++
 tb/tb_pio_bank.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pio_bank_if.sv
// Avalon-MM slave bundle for pio_bank: word-addressed register port plus level irq.
interface pio_bank_if #(
  parameter int AW = 5
);
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;

  modport master (output address, read, write, writedata, input readdata, irq);
  modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/pio_bank.sv
// Multi-lane parallel I/O bank: synchronised inputs, per-bit edge capture with irq mask,
// and outputs with direct write plus atomic set/clear.
module pio_lane #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int RESET_OUT   = 0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             det_en_i,
  input  logic             wr_i,
  input  logic [2:0]       reg_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] din_o,
  output logic [WIDTH-1:0] dout_o,
  output logic [WIDTH-1:0] mask_o,
  output logic [WIDTH-1:0] cap_o
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q, dout_q, dout_d, mask_q, mask_d, cap_q, cap_d, last, det;

  assign last = sync_q[SYNC_STAGES-1];

  always_comb begin
    det = '0;
    if (det_en_i) begin
      if (EDGE_MODE == 0)      det = last & ~prev_q;
      else if (EDGE_MODE == 1) det = ~last & prev_q;
      else                     det = last ^ prev_q;
    end
  end

  always_comb begin
    dout_d = dout_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_i) begin
      case (reg_i)
        3'd1:    dout_d = wd_i;
        3'd2:    mask_d = wd_i;
        3'd3:    cap_d  = cap_q & ~wd_i;
        3'd4:    dout_d = dout_q | wd_i;
        3'd5:    dout_d = dout_q & ~wd_i;
        default: ;
      endcase
    end
    // a fresh edge beats a simultaneous write-1-to-clear
    cap_d = cap_d | det;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_q <= '0;
      prev_q <= '0;
      dout_q <= {WIDTH{1'(RESET_OUT)}};
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= last;
      dout_q <= dout_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  assign din_o  = last;
  assign dout_o = dout_q;
  assign mask_o = mask_q;
  assign cap_o  = cap_q;
endmodule

module pio_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int RESET_OUT   = 0
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  pio_bank_if.slave                 bus,
  input  logic [CHANNELS*WIDTH-1:0] in_port,
  output logic [CHANNELS*WIDTH-1:0] out_port
);
  localparam int AW = $clog2(CHANNELS) + 3;

  logic [2:0] prime_q;
  logic       det_en;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0][WIDTH-1:0] din_w, dout_w, mask_w, cap_w;
  logic [WIDTH-1:0] rd_lane;
  logic [31:0] readdata_q;
  logic        irq_q;
  logic        unused_wd;

  assign unused_wd = ^bus.writedata;

  // detection stays off until the synchroniser and prev flop hold real samples
  assign det_en = (prime_q == 3'(SYNC_STAGES + 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset)  prime_q <= '0;
    else if (!det_en) prime_q <= prime_q + 3'd1;
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    assign hit[n] = ((bus.address >> 3) == AW'(n));

    pio_lane #(
      .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(EDGE_MODE), .RESET_OUT(RESET_OUT)
    ) u_lane (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .det_en_i    (det_en),
      .wr_i        (bus.write & hit[n]),
      .reg_i       (bus.address[2:0]),
      .wd_i        (bus.writedata[WIDTH-1:0]),
      .in_i        (in_port[n*WIDTH +: WIDTH]),
      .din_o       (din_w[n]),
      .dout_o      (dout_w[n]),
      .mask_o      (mask_w[n]),
      .cap_o       (cap_w[n])
    );

    assign out_port[n*WIDTH +: WIDTH] = dout_w[n];
  end

  // lanes beyond CHANNELS never hit, so they read as zero and swallow writes
  always_comb begin
    rd_lane = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (hit[n]) begin
        case (bus.address[2:0])
          3'd0:    rd_lane = din_w[n];
          3'd1:    rd_lane = dout_w[n];
          3'd2:    rd_lane = mask_w[n];
          3'd3:    rd_lane = cap_w[n];
          default: rd_lane = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (bus.read) readdata_q <= 32'(rd_lane);
      irq_q <= |(cap_w & mask_w);
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;
endmodule

// File: tb/tb_pio_bank.sv
// Directed bench for pio_bank: main 4-lane instance plus a 5-lane instance for out-of-range lanes.
module tb_pio_bank;
  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int SS  = 2;
  localparam int AW  = $clog2(CH) + 3;
  localparam int AW5 = $clog2(5) + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH*W-1:0] in_port, out_port;
  logic [5*W-1:0]  in5, out5;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] d;

  pio_bank_if #(.AW(AW))  bus  ();
  pio_bank_if #(.AW(AW5)) bus5 ();

  pio_bank #(.CHANNELS(CH), .WIDTH(W), .SYNC_STAGES(SS), .EDGE_MODE(0), .RESET_OUT(0)) dut (
    .clk_clk(clk), .reset_reset(rst), .bus(bus), .in_port(in_port), .out_port(out_port));

  pio_bank #(.CHANNELS(5), .WIDTH(W), .SYNC_STAGES(SS), .EDGE_MODE(0), .RESET_OUT(0)) dut5 (
    .clk_clk(clk), .reset_reset(rst), .bus(bus5), .in_port(in5), .out_port(out5));

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
  endtask

  task automatic wr(input int lane, input int r, input logic [31:0] wd, input bit b5 = 1'b0);
    if (b5) begin
      bus5.address = AW5'(lane * 8 + r); bus5.writedata = wd; bus5.write = 1'b1;
    end else begin
      bus.address = AW'(lane * 8 + r); bus.writedata = wd; bus.write = 1'b1;
    end
    tick();
    bus.write = 1'b0;
    bus5.write = 1'b0;
  endtask

  task automatic rd(input int lane, input int r, output logic [31:0] rdat, input bit b5 = 1'b0);
    if (b5) begin
      bus5.address = AW5'(lane * 8 + r); bus5.read = 1'b1;
    end else begin
      bus.address = AW'(lane * 8 + r); bus.read = 1'b1;
    end
    tick();
    bus.read = 1'b0;
    bus5.read = 1'b0;
    rdat = b5 ? bus5.readdata : bus.readdata;
  endtask

  initial begin
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    bus5.address = '0; bus5.read = 1'b0; bus5.write = 1'b0; bus5.writedata = '0;
    in5 = '0;

    // reset with all inputs held high: no spurious capture afterwards
    in_port = '1;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("rst_out", out_port, 32'h0);
    check("rst_irq", {31'h0, bus.irq}, 32'h0);
    check("rst_rdata", bus.readdata, 32'h0);
    for (int i = 0; i < CH; i++) begin
      rd(i, 3, d);
      check($sformatf("rst_cap%0d", i), d, 32'h0);
    end
    rd(2, 0, d);
    check("din_lane2", d, 32'h0000_00FF);

    // output register access
    wr(1, 1, 32'h5A);
    check("dout_wr", {24'h0, out_port[15:8]}, 32'h5A);
    wr(1, 4, 32'h81);
    check("dout_set", {24'h0, out_port[15:8]}, 32'hDB);
    wr(1, 5, 32'h18);
    check("dout_clr", {24'h0, out_port[15:8]}, 32'hC3);
    rd(1, 1, d);
    check("dout_rd", d, 32'hC3);
    tick(2);
    check("rdata_hold", bus.readdata, 32'hC3);

    // rising-edge capture and irq latency on lane3 bit2
    in_port = '0;
    tick(6);
    wr(3, 2, 32'h04);
    in_port[26] = 1'b1;
    for (int k = 1; k <= SS + 2; k++) begin
      tick();
      check($sformatf("irq_lat%0d", k), {31'h0, bus.irq}, {31'h0, k == SS + 2});
    end
    rd(3, 3, d);
    check("cap_lane3", d, 32'h04);
    wr(3, 3, 32'h04);
    check("irq_hold_w1c", {31'h0, bus.irq}, 32'h1);
    tick();
    check("irq_fall", {31'h0, bus.irq}, 32'h0);

    // W1C landing on the same edge as the capture: set wins
    in_port[0] = 1'b1;
    tick(2);
    wr(0, 3, 32'h01);
    rd(0, 3, d);
    check("w1c_collide", d, 32'h01);
    wr(0, 3, 32'h01);
    rd(0, 3, d);
    check("w1c_plain", d, 32'h00);

    // masked-off edge on lane1 bit0
    in_port[8] = 1'b1;
    tick(5);
    check("masked_irq", {31'h0, bus.irq}, 32'h0);
    rd(1, 3, d);
    check("masked_cap", d, 32'h01);

    // reserved regs and DATA_IN are inert
    rd(1, 6, d);
    check("rsvd_rd", d, 32'h0);
    wr(1, 6, 32'hFF);
    wr(1, 7, 32'hFF);
    wr(1, 0, 32'h00);
    check("rsvd_wr_out", out_port, 32'h0000_C300);
    rd(1, 2, d);
    check("rsvd_wr_mask", d, 32'h0);
    rd(1, 3, d);
    check("rsvd_wr_cap", d, 32'h01);

    // nonexistent lane 5 on the 5-lane instance
    wr(1, 1, 32'h33, 1'b1);
    rd(5, 1, d, 1'b1);
    check("oob_rd", d, 32'h0);
    wr(5, 1, 32'hFF, 1'b1);
    wr(5, 4, 32'hFF, 1'b1);
    wr(5, 2, 32'hFF, 1'b1);
    check("oob_out_lo", out5[31:0], 32'h0000_3300);
    check("oob_out_hi", {24'h0, out5[39:32]}, 32'h0);
    rd(1, 1, d, 1'b1);
    check("oob_lane1", d, 32'h33);

    // reset mid-operation with a concurrent write
    in_port[23:16] = 8'hFF;
    wr(2, 2, 32'hFF);
    tick(4);
    check("pre_rst_irq", {31'h0, bus.irq}, 32'h1);
    rd(2, 3, d);
    check("pre_rst_cap", d, 32'hFF);
    bus.address = AW'(0 * 8 + 1); bus.writedata = 32'hAA; bus.write = 1'b1;
    rst = 1'b1;
    tick();
    bus.write = 1'b0;
    rst = 1'b0;
    check("mid_rst_out", out_port, 32'h0);
    check("mid_rst_irq", {31'h0, bus.irq}, 32'h0);
    check("mid_rst_rdata", bus.readdata, 32'h0);
    tick(10);
    rd(2, 3, d);
    check("post_rst_cap", d, 32'h0);
    rd(2, 2, d);
    check("post_rst_mask", d, 32'h0);
    check("post_rst_irq", {31'h0, bus.irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
